// File: rtl/aucohl_tmr32_shadow_if.sv
// Configuration bus between the register front-end and the timer shadow stage.
// wr_en and force_upd are single-cycle strobes that are always accepted: there is no ready, and each high cycle is one command.
interface aucohl_tmr32_shadow_if #(
  parameter int PRW = 16
);
  logic           wr_en;
  logic [1:0]     wr_sel;
  logic [31:0]    wr_data;
  logic           upd_mode;
  logic           force_upd;
  logic           tmr_en;
  logic           timeout_flag;
  logic [31:0]    tmr_reload;
  logic [31:0]    cmpx;
  logic [31:0]    cmpy;
  logic [PRW-1:0] prescaler;
  logic [3:0]     pending;
  logic           upd_pulse;

  modport master (
    output wr_en, wr_sel, wr_data, upd_mode, force_upd, tmr_en, timeout_flag,
    input  tmr_reload, cmpx, cmpy, prescaler, pending, upd_pulse
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, upd_mode, force_upd, tmr_en, timeout_flag,
    output tmr_reload, cmpx, cmpy, prescaler, pending, upd_pulse
  );
endinterface

// File: rtl/aucohl_tmr32_shadow.sv
// Double-buffered reload/compare/prescaler registers for the 32-bit timer core.
// Shadows move to the active copies together, so the core never sees a half-updated period.
module aucohl_tmr32_shadow #(
  parameter int PRW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  aucohl_tmr32_shadow_if.slave  bus
);

  localparam logic [1:0] SEL_RELOAD = 2'd0;
  localparam logic [1:0] SEL_CMPX   = 2'd1;
  localparam logic [1:0] SEL_CMPY   = 2'd2;
  localparam logic [1:0] SEL_PRESC  = 2'd3;

  logic [31:0]    reload_sh_q, reload_sh_d;
  logic [31:0]    cmpx_sh_q, cmpx_sh_d;
  logic [31:0]    cmpy_sh_q, cmpy_sh_d;
  logic [PRW-1:0] presc_sh_q, presc_sh_d;
  logic [31:0]    reload_act_q, reload_act_d;
  logic [31:0]    cmpx_act_q, cmpx_act_d;
  logic [31:0]    cmpy_act_q, cmpy_act_d;
  logic [PRW-1:0] presc_act_q, presc_act_d;
  logic [3:0]     pending_q, pending_d;
  logic           timeout_q, timeout_d;
  logic           upd_pulse_q, upd_pulse_d;

  logic bnd;
  logic xfer;
  logic do_xfer;

  always_comb begin
    reload_sh_d  = reload_sh_q;
    cmpx_sh_d    = cmpx_sh_q;
    cmpy_sh_d    = cmpy_sh_q;
    presc_sh_d   = presc_sh_q;
    reload_act_d = reload_act_q;
    cmpx_act_d   = cmpx_act_q;
    cmpy_act_d   = cmpy_act_q;
    presc_act_d  = presc_act_q;
    pending_d    = pending_q;
    timeout_d    = bus.timeout_flag;

    // Only the first clock of a multi-cycle timeout_flag high is a period boundary.
    bnd     = bus.timeout_flag & ~timeout_q;
    xfer    = bus.force_upd | ~bus.tmr_en | ~bus.upd_mode | bnd;
    do_xfer = xfer & (|pending_q);
    upd_pulse_d = do_xfer;

    if (do_xfer) begin
      if (pending_q[SEL_RELOAD]) reload_act_d = reload_sh_q;
      if (pending_q[SEL_CMPX])   cmpx_act_d   = cmpx_sh_q;
      if (pending_q[SEL_CMPY])   cmpy_act_d   = cmpy_sh_q;
      if (pending_q[SEL_PRESC])  presc_act_d  = presc_sh_q;
      pending_d = 4'b0000;
    end

    // A write in the transfer cycle lands after the old shadow was copied, so it stays pending.
    if (bus.wr_en) begin
      case (bus.wr_sel)
        SEL_RELOAD: reload_sh_d = bus.wr_data;
        SEL_CMPX:   cmpx_sh_d   = bus.wr_data;
        SEL_CMPY:   cmpy_sh_d   = bus.wr_data;
        SEL_PRESC:  presc_sh_d  = bus.wr_data[PRW-1:0];
        default:    reload_sh_d = reload_sh_q;
      endcase
      pending_d[bus.wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_sh_q  <= '0;
      cmpx_sh_q    <= '0;
      cmpy_sh_q    <= '0;
      presc_sh_q   <= '0;
      reload_act_q <= '0;
      cmpx_act_q   <= '0;
      cmpy_act_q   <= '0;
      presc_act_q  <= '0;
      pending_q    <= '0;
      timeout_q    <= 1'b0;
      upd_pulse_q  <= 1'b0;
    end else begin
      reload_sh_q  <= reload_sh_d;
      cmpx_sh_q    <= cmpx_sh_d;
      cmpy_sh_q    <= cmpy_sh_d;
      presc_sh_q   <= presc_sh_d;
      reload_act_q <= reload_act_d;
      cmpx_act_q   <= cmpx_act_d;
      cmpy_act_q   <= cmpy_act_d;
      presc_act_q  <= presc_act_d;
      pending_q    <= pending_d;
      timeout_q    <= timeout_d;
      upd_pulse_q  <= upd_pulse_d;
    end
  end

  assign bus.tmr_reload = reload_act_q;
  assign bus.cmpx       = cmpx_act_q;
  assign bus.cmpy       = cmpy_act_q;
  assign bus.prescaler  = presc_act_q;
  assign bus.pending    = pending_q;
  assign bus.upd_pulse  = upd_pulse_q;

endmodule

// File: doc/aucohl_tmr32_shadow.md
# aucohl_tmr32_shadow

Double-buffered configuration stage sitting directly upstream of the 32-bit timer/PWM core. Holds bus-written shadow copies of the reload, compare-X, compare-Y and prescaler values, and drives the active copies into the timer core. Transfers happen immediately while the timer is disabled, or otherwise only at a period boundary (rising edge of the core's `timeout_flag`) or on software force, so that period and duty changes never tear mid-period.

## Interface
Parameters:
- `PRW`, default 16: prescaler width; must match the timer core's `PRW`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  one-cycle write strobe for a shadow register.
- `wr_sel`  in  2  target select: 0 = reload, 1 = cmpx, 2 = cmpy, 3 = prescaler.
- `wr_data`  in  32  write data; for prescaler only `[PRW-1:0]` is used and upper bits are ignored.
- `upd_mode`  in  1  0 = immediate, 1 = buffered (transfer at period boundary).
- `force_upd`  in  1  one-cycle strobe that transfers all pending shadows now.
- `tmr_en`  in  1  timer enable, same signal that feeds the core.
- `timeout_flag`  in  1  level flag from the timer core.
- `tmr_reload`  out  32  active reload value to the core.
- `cmpx`  out  32  active compare X value.
- `cmpy`  out  32  active compare Y value.
- `prescaler`  out  PRW  active prescaler value.
- `pending`  out  4  per-register "shadow differs from active, not yet transferred" bits, indexed as `wr_sel`.
- `upd_pulse`  out  1  high for one cycle when any transfer lands in the active registers.

## Operation
- Storage:
  - four shadow registers;
  - four active registers;
  - 4-bit `pending`;
  - `timeout_q`, a one-cycle delayed copy of `timeout_flag`.
- Boundary event `bnd = timeout_flag & ~timeout_q`, i.e. the rising edge.
  - The core holds `timeout_flag` high for a whole prescaler tick, which can be several clocks.
  - Only the first clock of that high period counts as a boundary.
- Write handling: `wr_en` loads `shadow[wr_sel]` and sets `pending[wr_sel]`.
- Transfer condition `xfer`, true if any of:
  - `force_upd`;
  - `~tmr_en`;
  - `upd_mode == 0`;
  - `upd_mode == 1 & bnd`.
- Transfer action: when `xfer` is true and `pending != 0`, every register whose pending bit is set copies shadow → active in the same cycle. That pending bit clears, and `upd_pulse` asserts on the next cycle.
  - All pending registers move together. A partial group transfer is not allowed.
- Same-cycle write and transfer:
  - The transfer uses the shadow contents registered before this cycle.
  - The written register takes the new shadow value and stays pending; its pending bit is set, not cleared.
  - Exception: in immediate mode or with `tmr_en == 0`, the write itself is the trigger. The new data reaches the active register one cycle later, through the normal path.
- Repeated writes to one register before a boundary: the last one wins. `pending` stays set.
- `upd_mode` change from 1 to 0 while entries are pending: they transfer on the next cycle.
- `force_upd` with nothing pending: no register change and no `upd_pulse`.
- Reset (any cycle, including mid-period) sets:
  - all shadows and actives to 0;
  - `pending` = 0;
  - `timeout_q` = 0;
  - `upd_pulse` = 0.
  - No write survives reset.

## Timing
- Reset values: `tmr_reload` = 0, `cmpx` = 0, `cmpy` = 0, `prescaler` = 0, `pending` = 0, `upd_pulse` = 0.
- Immediate path (`upd_mode == 0` or `tmr_en == 0`):
  - `wr_en` in cycle N → `pending` bit high in cycle N+1, cleared in N+2;
  - active register updated in cycle N+2;
  - `upd_pulse` high in cycle N+2.
  - Bench checks the register value at N+2.
- Buffered path:
  - `timeout_flag` is first sampled high in cycle M (`bnd` in M).
  - Actives are updated and `pending` cleared as visible in M+1.
  - `upd_pulse` high in M+1.
  - Further high cycles of `timeout_flag` cause no transfer.
- `force_upd` in cycle F → actives updated and `upd_pulse` high in F+1.
- `upd_pulse` is never high for two consecutive cycles unless transfers occur on two consecutive cycles.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset then idle: all outputs are 0, `pending` = 0, and `upd_pulse` never asserts over 50 cycles.
- `tmr_en=0`, write reload=0x0000_00FF: `tmr_reload`=0xFF after 2 cycles, `upd_pulse` fires once, `pending`=0.
- `tmr_en=1`, `upd_mode=1`, write cmpx=0x40 and cmpy=0x80:
  - `pending`=4'b0110 and actives unchanged while `timeout_flag`=0;
  - raise `timeout_flag` for 4 cycles → both actives change together exactly one cycle after the rise, with a single `upd_pulse`.
- Write reload=0x100 in the same cycle as `bnd`, with the earlier pending cmpx=0x10: cmpx transfers; reload stays pending with `pending`=4'b0001; the next boundary transfers reload=0x100.
- Buffered mode, write prescaler=0x7, pulse `force_upd`: `prescaler`=7 one cycle after the force; a later `force_upd` with nothing pending gives no `upd_pulse`.
- Assert `rst` for 1 cycle while `pending`=4'b1111: all shadows, actives and `pending` are 0 afterwards, and a following boundary produces no `upd_pulse`.
